sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO, the next generation of the SPI/GPIO peripheral FIFO. Depth and width are configurable. It supports a simultaneous read and write in the same cycle, sticky overflow and underflow flags, an occupancy count and optional watermark flags. Address and chip-select decoding move out to the register wrapper, which drives the qualified `Write` and `Read` strobes. The block sits between the Avalon register interface and the SPI shift engine, one instance per direction (TX and RX).

## Interface
- `WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 16: number of entries; must be a power of two, at least 2.
- `AF_LEVEL`, default 12: AlmostFull threshold, compared as Count >= AF_LEVEL.
- `AE_LEVEL`, default 4: AlmostEmpty threshold, compared as Count <= AE_LEVEL.
- `Clock`  in  1: rising-edge clock.
- `Reset`  in  1: reset, asynchronous, active-high.
- `Write`  in  1: write request, already qualified by address and chip-select.
- `Read`  in  1: read request, already qualified.
- `ClearFlags`  in  1: synchronous clear of Overflow and Underflow.
- `DataIn`  in  WIDTH: write data.
- `DataOut`  out  WIDTH: registered read data.
- `Count`  out  PTR_W+1: occupancy, 0..DEPTH. PTR_W = clog2(DEPTH).
- `Full`  out  1: Count == DEPTH.
- `Empty`  out  1: Count == 0.
- `AlmostFull`  out  1: watermark flag.
- `AlmostEmpty`  out  1: watermark flag.
- `Overflow`  out  1: sticky; a write was refused.
- `Underflow`  out  1: sticky; a read was refused.
- `ReadPtr`  out  PTR_W: read pointer.
- `WritePtr`  out  PTR_W: write pointer.

## Operation
- Read accept: rd_ok = Read & !Empty.
- Write accept: wr_ok = Write & (!Full | rd_ok).
  - When full, a write in the same cycle as an accepted read is accepted.
  - When empty, a simultaneous read is refused and the write is accepted.
- On rd_ok:
  - DataOut <= mem[ReadPtr].
  - ReadPtr increments and wraps modulo DEPTH.
- On wr_ok:
  - mem[WritePtr] <= DataIn.
  - WritePtr increments and wraps modulo DEPTH.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Count never exceeds DEPTH and never goes below 0.
- Overflow is set when Write & !wr_ok.
- Underflow is set when Read & Empty.
- Both flags stay set until ClearFlags. If set and clear occur in the same cycle, set wins.
- Flags never block traffic: reads and writes proceed normally while Overflow or Underflow is set.
- A refused write leaves memory, pointers and Count untouched.
- A refused read leaves DataOut holding its previous value.
- Full, Empty, AlmostFull and AlmostEmpty are combinational decodes of the registered Count.

## Timing
- Reset (asynchronous, immediate) forces:
  - Count = 0, pointers = 0, DataOut = 0.
  - Overflow = 0, Underflow = 0.
  - Empty = 1, Full = 0, AlmostEmpty = 1, AlmostFull = 0.
- Memory contents are not reset and are undefined until written.
- Read latency: DataOut is valid on the edge after the cycle in which Read is accepted, and holds until the next accepted read.
- Write-to-read: a word written in cycle N can be read in cycle N+1. Empty deasserts after edge N.
- Status outputs update on the same edge as Count.
- Reset asserted mid-burst discards all contents. The first operation after reset deassertion sees an empty FIFO.

## Configuration
- Macro `SYNC_FIFO_WATERMARK_EN`.
  - Defined: AlmostFull and AlmostEmpty are driven from AF_LEVEL and AE_LEVEL as above.
  - Undefined: both outputs are tied to 0, and the threshold compare logic is not built.
- All other behaviour is identical in both builds.

## Structure
- Shared package `fifo_pkg` holds:
  - the clog2 helper;
  - default constants FIFO_DEPTH_DEF = 16, FIFO_WIDTH_DEF = 32, AF_LEVEL_DEF = 12, AE_LEVEL_DEF = 4.
- One sub-module, `fifo_ram`: a DEPTH x WIDTH array with one synchronous write port and a registered read port. Its read register is DataOut.
- Pointer, count and flag logic stay in the top level.

## Test plan
- Reset, then write 16 words 0x1..0x10 with DEPTH=16:
  - Full=1 and Count=16 after the 16th write.
  - A 17th write sets Overflow=1 and leaves Count=16.
- From full, Read and Write (0xAA) in the same cycle:
  - Both are accepted and Count stays 16.
  - DataOut=0x1 next cycle.
  - 0xAA is read out as the 16th word after 15 further reads.
- Read on an empty FIFO:
  - Underflow=1, DataOut unchanged, Count=0.
  - ClearFlags then gives Underflow=0 on the next edge.
- Write and read 40 words interleaved: pointers wrap twice, and data order and values are preserved.
- Watermark with the macro defined:
  - Count=11 gives AlmostFull=0; Count=12 gives AlmostFull=1.
  - Count=4 gives AlmostEmpty=1; Count=5 gives AlmostEmpty=0.
  - With the macro undefined, both flags stay 0 throughout.
- Reset asserted asynchronously with Count=7 and Overflow=1:
  - All outputs reach their reset values without waiting for a clock edge.
  - After deassertion, a write of 0x55 followed by a read returns 0x55.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and the clog2 helper for the peripheral FIFO family.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_WIDTH_DEF = 32;
    localparam int AF_LEVEL_DEF   = 12;
    localparam int AE_LEVEL_DEF   = 4;

    // Number of address bits needed to index 'value' entries.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and a registered read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             write_en,
    input  logic [PTR_W-1:0] write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    input  logic [PTR_W-1:0] read_addr,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] read_data_reg;

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge Clock) begin
        if (write_en) begin
            mem_reg[write_addr] <= write_data;
        end
    end

    // A read to the slot being written in the same cycle returns the old word.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            read_data_reg <= '0;
        end else if (read_en) begin
            read_data_reg <= mem_reg[read_addr];
        end
    end

    assign read_data = read_data_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with sticky error flags and occupancy count.
// Watermark flags are built only when SYNC_FIFO_WATERMARK_EN is defined.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = AF_LEVEL_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF,
    localparam int PTR_W   = clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Write,
    input  logic             Read,
    input  logic             ClearFlags,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataOut,
    output logic [PTR_W:0]   Count,
    output logic             Full,
    output logic             Empty,
    output logic             AlmostFull,
    output logic             AlmostEmpty,
    output logic             Overflow,
    output logic             Underflow,
    output logic [PTR_W-1:0] ReadPtr,
    output logic [PTR_W-1:0] WritePtr
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);

    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             rd_ok;
    logic             wr_ok;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok      = Read && !Empty;
        wr_ok      = Write && (!Full || rd_ok);
        count_next = count_reg;
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            // Setting takes priority over a clear arriving in the same cycle.
            if (Write && !wr_ok) begin
                overflow_reg <= 1'b1;
            end else if (ClearFlags) begin
                overflow_reg <= 1'b0;
            end
            if (Read && Empty) begin
                underflow_reg <= 1'b1;
            end else if (ClearFlags) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .Clock      (Clock),
        .Reset      (Reset),
        .write_en   (wr_ok),
        .write_addr (wr_ptr_reg),
        .write_data (DataIn),
        .read_en    (rd_ok),
        .read_addr  (rd_ptr_reg),
        .read_data  (DataOut)
    );

    assign Count     = count_reg;
    assign Full      = (count_reg == DEPTH_C);
    assign Empty     = (count_reg == '0);
    assign Overflow  = overflow_reg;
    assign Underflow = underflow_reg;
    assign ReadPtr   = rd_ptr_reg;
    assign WritePtr  = wr_ptr_reg;

`ifdef SYNC_FIFO_WATERMARK_EN
    localparam logic [PTR_W:0] AF_C = (PTR_W + 1)'(AF_LEVEL);
    localparam logic [PTR_W:0] AE_C = (PTR_W + 1)'(AE_LEVEL);

    assign AlmostFull  = (count_reg >= AF_C);
    assign AlmostEmpty = (count_reg <= AE_C);
`else
    assign AlmostFull  = 1'b0;
    assign AlmostEmpty = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at default parameters.
module tb_sync_fifo_param;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int PW = 4;

    logic          Clock;
    logic          Reset;
    logic          Write;
    logic          Read;
    logic          ClearFlags;
    logic [W-1:0]  DataIn;
    logic [W-1:0]  DataOut;
    logic [PW:0]   Count;
    logic          Full;
    logic          Empty;
    logic          AlmostFull;
    logic          AlmostEmpty;
    logic          Overflow;
    logic          Underflow;
    logic [PW-1:0] ReadPtr;
    logic [PW-1:0] WritePtr;

    sync_fifo_param dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Write       (Write),
        .Read        (Read),
        .ClearFlags  (ClearFlags),
        .DataIn      (DataIn),
        .DataOut     (DataOut),
        .Count       (Count),
        .Full        (Full),
        .Empty       (Empty),
        .AlmostFull  (AlmostFull),
        .AlmostEmpty (AlmostEmpty),
        .Overflow    (Overflow),
        .Underflow   (Underflow),
        .ReadPtr     (ReadPtr),
        .WritePtr    (WritePtr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] model_q [$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] dout_m;
    bit           ovf_m;
    bit           unf_m;
    int           rp_m;
    int           wp_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        dout_m = '0;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
        rp_m   = 0;
        wp_m   = 0;
    endtask

    task automatic check_status(input string tag);
        int  n;
        bit  af;
        bit  ae;
        n = model_q.size();
`ifdef SYNC_FIFO_WATERMARK_EN
        af = (n >= 12);
        ae = (n <= 4);
`else
        af = 1'b0;
        ae = 1'b0;
`endif
        check({tag, ".count"}, 64'(Count), 64'(n));
        check({tag, ".full"}, 64'(Full), 64'(n == D));
        check({tag, ".empty"}, 64'(Empty), 64'(n == 0));
        check({tag, ".afull"}, 64'(AlmostFull), 64'(af));
        check({tag, ".aempty"}, 64'(AlmostEmpty), 64'(ae));
        check({tag, ".ovf"}, 64'(Overflow), 64'(ovf_m));
        check({tag, ".unf"}, 64'(Underflow), 64'(unf_m));
        check({tag, ".rptr"}, 64'(ReadPtr), 64'(rp_m));
        check({tag, ".wptr"}, 64'(WritePtr), 64'(wp_m));
        check({tag, ".dout"}, 64'(DataOut), 64'(dout_m));
    endtask

    // One clock of stimulus; expected read data is queued at drive time and
    // retired when the DUT register has taken it.
    task automatic step(input bit wr, input bit rd, input bit clr, input logic [W-1:0] data);
        bit rd_ok;
        bit wr_ok;
        Write      = wr;
        Read       = rd;
        ClearFlags = clr;
        DataIn     = data;
        rd_ok = rd && (model_q.size() > 0);
        wr_ok = wr && ((model_q.size() < D) || rd_ok);
        if (rd_ok) begin
            exp_q.push_back(model_q.pop_front());
            rp_m = (rp_m + 1) % D;
        end
        if (wr_ok) begin
            model_q.push_back(data);
            wp_m = (wp_m + 1) % D;
        end
        if (wr && !wr_ok) ovf_m = 1'b1;
        else if (clr)     ovf_m = 1'b0;
        if (rd && !rd_ok) unf_m = 1'b1;
        else if (clr)     unf_m = 1'b0;
        @(posedge Clock);
        #1;
        Write      = 1'b0;
        Read       = 1'b0;
        ClearFlags = 1'b0;
        if (rd_ok) dout_m = exp_q.pop_front();
        $display("txn wr=%0b rd=%0b clr=%0b din=%h -> count=%0d dout=%h ovf=%0b unf=%0b",
                 wr, rd, clr, data, Count, DataOut, Overflow, Underflow);
        check_status("step");
    endtask

    initial begin
        Reset      = 1'b1;
        Write      = 1'b0;
        Read       = 1'b0;
        ClearFlags = 1'b0;
        DataIn     = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_status("reset");
        Reset = 1'b0;
        check_status("post_reset");

        // Fill to full, then one refused write
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, W'(i));
        check("full16.full", 64'(Full), 64'd1);
        check("full16.count", 64'(Count), 64'd16);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("w17.ovf", 64'(Overflow), 64'd1);
        check("w17.count", 64'(Count), 64'd16);

        // Simultaneous read and write while full
        step(1'b1, 1'b1, 1'b0, 32'h0000_00AA);
        check("rw_full.dout", 64'(DataOut), 64'h1);
        check("rw_full.count", 64'(Count), 64'd16);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check("aa_last.dout", 64'(DataOut), 64'hAA);
        check("aa_last.empty", 64'(Empty), 64'd1);

        // Read on empty, set-wins, then clear
        step(1'b0, 1'b1, 1'b0, '0);
        check("unf.set", 64'(Underflow), 64'd1);
        check("unf.dout", 64'(DataOut), 64'hAA);
        check("unf.count", 64'(Count), 64'd0);
        step(1'b0, 1'b1, 1'b1, '0);
        check("unf.set_wins", 64'(Underflow), 64'd1);
        step(1'b0, 1'b0, 1'b1, '0);
        check("unf.cleared", 64'(Underflow), 64'd0);

        // Empty with read and write together: write taken, read refused
        step(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D);
        check("rw_empty.count", 64'(Count), 64'd1);
        check("rw_empty.unf", 64'(Underflow), 64'd1);
        step(1'b0, 1'b0, 1'b1, '0);

        // 40 interleaved words; write pointer wraps twice
        step(1'b1, 1'b0, 1'b0, 32'h1000_0000);
        for (int i = 1; i < 40; i++) step(1'b1, 1'b1, 1'b0, 32'h1000_0000 + W'(i * 7));
        while (model_q.size() > 0) step(1'b0, 1'b1, 1'b0, '0);
        check("ilv.last", 64'(DataOut), 64'(32'h1000_0000 + 39 * 7));

        // Count=7 with Overflow set, then asynchronous reset
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 32'h2000_0000 + W'(i));
        step(1'b1, 1'b0, 1'b0, 32'h2FFF_FFFF);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, '0);
        check("pre_rst.count", 64'(Count), 64'd7);
        check("pre_rst.ovf", 64'(Overflow), 64'd1);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_status("async_rst");
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h0000_0055);
        step(1'b0, 1'b1, 1'b0, '0);
        check("rst_55.dout", 64'(DataOut), 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
